// File: rtl/lkh_route_rr_pipe.sv
// Round-robin shared look-ahead routing engine for MESH/TORUS routers, one result per cycle.
// Define LKH_ROUTE_ERR_CHK_EN to enable mesh edge-violation detection on rsp_err.
module lkh_route_rr_pipe #(
    parameter string TOPOLOGY   = "MESH",
    parameter string ROUTE_NAME = "XY",
    parameter int    NX         = 4,
    parameter int    NY         = 4,
    parameter int    NCH        = 5,
    parameter int    RXw        = $clog2(NX),
    parameter int    RYw        = $clog2(NY)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [RXw-1:0]     current_rx,
    input  logic [RYw-1:0]     current_ry,
    input  logic [NCH-1:0]     req_valid,
    output logic [NCH-1:0]     req_ready,
    input  logic [NCH*RXw-1:0] req_dest_x,
    input  logic [NCH*RYw-1:0] req_dest_y,
    input  logic [NCH*3-1:0]   req_destport,
    output logic [NCH-1:0]     rsp_valid,
    input  logic [NCH-1:0]     rsp_ready,
    output logic [NCH*3-1:0]   rsp_lkdestport,
    output logic [NCH-1:0]     rsp_err
);

    localparam logic [2:0] P_LOCAL = 3'd0;
    localparam logic [2:0] P_EAST  = 3'd1;
    localparam logic [2:0] P_NORTH = 3'd2;
    localparam logic [2:0] P_WEST  = 3'd3;
    localparam logic [2:0] P_SOUTH = 3'd4;

    localparam bit IS_TORUS = (TOPOLOGY == "TORUS");
    localparam bit IS_YX    = (ROUTE_NAME == "YX");
    localparam int PW       = (NCH > 1) ? $clog2(NCH) : 1;

    // One step along a dimension with modular wrap; explicit compares keep non-power-of-two sizes exact.
    function automatic int next_coord(input int c, input int n, input bit pos, input bit neg);
        int r;
        r = c;
        if (pos)
            r = (c == n - 1) ? 0 : c + 1;
        else if (neg)
            r = (c == 0) ? n - 1 : c - 1;
        return r;
    endfunction

    // 0: aligned, 1: move positive (EAST/SOUTH), 2: move negative (WEST/NORTH).
    function automatic logic [1:0] dim_dir(input int here, input int dst, input int size);
        int dp;
        if (here == dst)
            return 2'd0;
        if (IS_TORUS) begin
            dp = (dst >= here) ? dst - here : dst + size - here;
            return (dp <= size - dp) ? 2'd1 : 2'd2;
        end
        return (dst > here) ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [2:0] pick_port(input logic [1:0] dx, input logic [1:0] dy);
        logic [2:0] px;
        logic [2:0] py;
        px = (dx == 2'd1) ? P_EAST : P_WEST;
        py = (dy == 2'd1) ? P_SOUTH : P_NORTH;
        if (IS_YX) begin
            if (dy != 2'd0) return py;
            if (dx != 2'd0) return px;
        end else begin
            if (dx != 2'd0) return px;
            if (dy != 2'd0) return py;
        end
        return P_LOCAL;
    endfunction

`ifdef LKH_ROUTE_ERR_CHK_EN
    function automatic bit edge_move(input int c, input int n, input bit pos, input bit neg);
        return (pos && (c == n - 1)) || (neg && (c == 0));
    endfunction
`endif

    logic [PW-1:0]    ptr;
    logic [NCH-1:0]   eligible;
    logic             vld_p0;
    int               gnt_idx_p0;
    int               best_off;
    int               off;
    logic [RXw-1:0]   dx_p0;
    logic [RYw-1:0]   dy_p0;
    logic [2:0]       dport_p0;
    int               nx_p0;
    int               ny_p0;
    logic [1:0]       dir_x_p0;
    logic [1:0]       dir_y_p0;
    logic [2:0]       lkport_p0;
    logic [NCH-1:0]   vld_p1;
    logic [NCH*3-1:0] port_p1;

    // ---- Stage p0: arbitration and look-ahead route computation ----
    assign eligible = req_valid & (~vld_p1 | rsp_ready);

    always_comb begin
        vld_p0     = 1'b0;
        gnt_idx_p0 = 0;
        best_off   = NCH;
        off        = 0;
        for (int i = 0; i < NCH; i++) begin
            off = i - int'(ptr) - 1;
            if (off < 0)
                off = off + NCH;
            if (eligible[i] && (off < best_off)) begin
                best_off   = off;
                gnt_idx_p0 = i;
                vld_p0     = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        dx_p0     = '0;
        dy_p0     = '0;
        dport_p0  = P_LOCAL;
        for (int i = 0; i < NCH; i++) begin
            if (gnt_idx_p0 == i) begin
                req_ready[i] = reset && vld_p0;
                dx_p0        = req_dest_x[i*RXw +: RXw];
                dy_p0        = req_dest_y[i*RYw +: RYw];
                dport_p0     = req_destport[i*3 +: 3];
            end
        end
    end

`ifdef LKH_ROUTE_ERR_CHK_EN
    logic err_p0;
`endif

    always_comb begin
        nx_p0     = next_coord(int'(current_rx), NX, dport_p0 == P_EAST, dport_p0 == P_WEST);
        ny_p0     = next_coord(int'(current_ry), NY, dport_p0 == P_SOUTH, dport_p0 == P_NORTH);
        dir_x_p0  = dim_dir(nx_p0, int'(dx_p0), NX);
        dir_y_p0  = dim_dir(ny_p0, int'(dy_p0), NY);
        lkport_p0 = (dport_p0 == P_LOCAL) ? P_LOCAL : pick_port(dir_x_p0, dir_y_p0);
`ifdef LKH_ROUTE_ERR_CHK_EN
        err_p0 = !IS_TORUS &&
                 (edge_move(int'(current_rx), NX, dport_p0 == P_EAST, dport_p0 == P_WEST) ||
                  edge_move(int'(current_ry), NY, dport_p0 == P_SOUTH, dport_p0 == P_NORTH));
        if (err_p0)
            lkport_p0 = P_LOCAL;
`endif
    end

    // ---- Stage p1: per-channel result registers, held until consumed ----
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr     <= PW'(NCH - 1);
            vld_p1  <= '0;
            port_p1 <= '0;
        end else begin
            if (vld_p0)
                ptr <= PW'(gnt_idx_p0);
            for (int i = 0; i < NCH; i++) begin
                if (req_ready[i]) begin
                    vld_p1[i]          <= 1'b1;
                    port_p1[i*3 +: 3]  <= lkport_p0;
                end else if (rsp_ready[i]) begin
                    vld_p1[i] <= 1'b0;
                end
            end
        end
    end

`ifdef LKH_ROUTE_ERR_CHK_EN
    logic [NCH-1:0] err_p1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            err_p1 <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (req_ready[i])
                    err_p1[i] <= err_p0;
            end
        end
    end

    assign rsp_err = err_p1;
`else
    assign rsp_err = '0;
`endif

    assign rsp_valid      = vld_p1;
    assign rsp_lkdestport = port_p1;

endmodule

// File: tb/tb_lkh_route_rr_pipe.sv
// Directed self-checking bench for lkh_route_rr_pipe: MESH XY, MESH YX and TORUS XY instances share stimulus.
module tb_lkh_route_rr_pipe;

    localparam int NCH = 5;

`ifdef LKH_ROUTE_ERR_CHK_EN
    localparam int ERR_ON = 1;
`else
    localparam int ERR_ON = 0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    cur_rx;
    logic [1:0]    cur_ry;
    logic [4:0]    req_valid;
    logic [9:0]    req_dest_x;
    logic [9:0]    req_dest_y;
    logic [14:0]   req_destport;
    logic [4:0]    rsp_ready;

    logic [4:0]    rdy_m, vld_m, err_m;
    logic [14:0]   port_m;
    logic [4:0]    rdy_y, vld_y, err_y;
    logic [14:0]   port_y;
    logic [4:0]    rdy_t, vld_t, err_t;
    logic [14:0]   port_t;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lkh_route_rr_pipe #(.TOPOLOGY("MESH"), .ROUTE_NAME("XY")) u_mxy (
        .clk(clk), .reset(reset), .current_rx(cur_rx), .current_ry(cur_ry),
        .req_valid(req_valid), .req_ready(rdy_m), .req_dest_x(req_dest_x),
        .req_dest_y(req_dest_y), .req_destport(req_destport), .rsp_valid(vld_m),
        .rsp_ready(rsp_ready), .rsp_lkdestport(port_m), .rsp_err(err_m)
    );

    lkh_route_rr_pipe #(.TOPOLOGY("MESH"), .ROUTE_NAME("YX")) u_myx (
        .clk(clk), .reset(reset), .current_rx(cur_rx), .current_ry(cur_ry),
        .req_valid(req_valid), .req_ready(rdy_y), .req_dest_x(req_dest_x),
        .req_dest_y(req_dest_y), .req_destport(req_destport), .rsp_valid(vld_y),
        .rsp_ready(rsp_ready), .rsp_lkdestport(port_y), .rsp_err(err_y)
    );

    lkh_route_rr_pipe #(.TOPOLOGY("TORUS"), .ROUTE_NAME("XY")) u_txy (
        .clk(clk), .reset(reset), .current_rx(cur_rx), .current_ry(cur_ry),
        .req_valid(req_valid), .req_ready(rdy_t), .req_dest_x(req_dest_x),
        .req_dest_y(req_dest_y), .req_destport(req_destport), .rsp_valid(vld_t),
        .rsp_ready(rsp_ready), .rsp_lkdestport(port_t), .rsp_err(err_t)
    );

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int pfield(input logic [14:0] v, input int ch);
        return int'(3'(v >> (3 * ch)));
    endfunction

    function automatic int bfield(input logic [4:0] v, input int ch);
        return int'(v >> ch) & 1;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Single request on one channel; returns after the accept edge with the result visible.
    task automatic send(input int ch, input logic [1:0] rx, input logic [1:0] ry,
                        input logic [1:0] dx, input logic [1:0] dy, input logic [2:0] dp);
        cur_rx       = rx;
        cur_ry       = ry;
        req_dest_x   = 10'(dx) << (2 * ch);
        req_dest_y   = 10'(dy) << (2 * ch);
        req_destport = 15'(dp) << (3 * ch);
        req_valid    = 5'(1) << ch;
        #1;
        chk("accept", bfield(rdy_m, ch), 1);
        cyc();
        req_valid = '0;
        chk("rsp_valid", bfield(vld_m, ch), 1);
    endtask

    initial begin
        int exp_stall[7];
        int waited;
        exp_stall = '{2, 4, 8, 16, 1, 2, 8};

        reset        = 1'b0;
        cur_rx       = 2'd1;
        cur_ry       = 2'd1;
        req_valid    = '1;
        req_dest_x   = '0;
        req_dest_y   = '0;
        req_destport = '0;
        rsp_ready    = '1;
        cyc();
        cyc();
        chk("reset_rsp_valid", int'(vld_m | vld_y | vld_t), 0);
        chk("reset_port", int'(port_m | port_y | port_t), 0);
        chk("reset_err", int'(err_m | err_y | err_t), 0);
        chk("reset_req_ready", int'(rdy_m | rdy_y | rdy_t), 0);
        req_valid = '0;
        reset     = 1'b1;

        // Mesh XY (1,1) east to (2,1), dest (3,2)
        send(0, 2'd1, 2'd1, 2'd3, 2'd2, 3'd1);
        chk("mxy_east", pfield(port_m, 0), 1);
        chk("mxy_err0", bfield(err_m, 0), 0);
        chk("myx_south", pfield(port_y, 0), 4);
        chk("txy_east", pfield(port_t, 0), 1);

        send(1, 2'd1, 2'd1, 2'd2, 2'd3, 3'd1);
        chk("mxy_xmatch_south", pfield(port_m, 1), 4);
        chk("txy_tie_south", pfield(port_t, 1), 4);

        send(2, 2'd1, 2'd1, 2'd3, 2'd2, 3'd4);
        chk("myx_ymatch_east", pfield(port_y, 2), 1);
        chk("mxy_east2", pfield(port_m, 2), 1);

        // Torus wrap from (3,0) east to (0,0)
        send(3, 2'd3, 2'd0, 2'd2, 2'd0, 3'd1);
        chk("torus_tie_east", pfield(port_t, 3), 1);
        chk("torus_err0", bfield(err_t, 3), 0);
        chk("mesh_east_edge_err", bfield(err_m, 3), ERR_ON);
`ifdef LKH_ROUTE_ERR_CHK_EN
        chk("mesh_east_edge_local", pfield(port_m, 3), 0);
`endif

        send(4, 2'd3, 2'd0, 2'd3, 2'd0, 3'd1);
        chk("torus_west", pfield(port_t, 4), 3);

        send(0, 2'd0, 2'd2, 2'd0, 2'd2, 3'd3);
        chk("torus_west_wrap", pfield(port_t, 0), 1);
        chk("mesh_west_edge_err", bfield(err_m, 0), ERR_ON);

        send(2, 2'd2, 2'd0, 2'd2, 2'd3, 3'd2);
        chk("torus_north_wrap_local", pfield(port_t, 2), 0);
        chk("mesh_north_edge_err", bfield(err_y, 2), ERR_ON);

        send(1, 2'd1, 2'd1, 2'd3, 2'd3, 3'd0);
        chk("destport_local_m", pfield(port_m, 1), 0);
        chk("destport_local_t", pfield(port_t, 1), 0);
        chk("destport_local_err", bfield(err_m, 1), 0);

        send(3, 2'd2, 2'd2, 2'd0, 2'd0, 3'd3);
        chk("mxy_west", pfield(port_m, 3), 3);
        chk("myx_north", pfield(port_y, 3), 2);
        chk("txy_west", pfield(port_t, 3), 3);
        chk("legal_err0", bfield(err_m, 3), 0);

        // Round-robin from a fresh reset
        reset = 1'b0;
        cyc();
        reset        = 1'b1;
        cur_rx       = 2'd1;
        cur_ry       = 2'd1;
        req_dest_x   = '0;
        req_dest_y   = '0;
        req_destport = '0;
        req_valid    = '1;
        #1;
        for (int k = 0; k < 6; k++) begin
            chk("rr_grant", int'(rdy_m), 1 << (k % NCH));
            cyc();
        end

        // Channel 2 result stalls; others keep rotating
        rsp_ready = 5'b11011;
        #1;
        for (int k = 0; k < 7; k++) begin
            chk("stall_grant", int'(rdy_m), exp_stall[k]);
            cyc();
        end
        chk("stall_held_valid", bfield(vld_m, 2), 1);
        chk("stall_held_port", pfield(port_m, 2), 0);

        rsp_ready = '1;
        #1;
        waited = 0;
        while (bfield(rdy_m, 2) == 0 && waited < NCH) begin
            cyc();
            waited++;
        end
        chk("stall_release_grant", bfield(rdy_m, 2), 1);

        // Reset in the middle of traffic
        reset = 1'b0;
        #1;
        chk("midreset_ready", int'(rdy_m | rdy_y | rdy_t), 0);
        cyc();
        chk("midreset_valid", int'(vld_m | vld_y | vld_t), 0);
        req_valid = '0;
        reset     = 1'b1;
        cyc();
        chk("post_reset_no_pulse", int'(vld_m | vld_y | vld_t), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
